axis_downsizer: RTL and testbench

- Parametrised AXI-Stream width downsizer that serializes each wide input beat into IN_WIDTH/OUT_WIDTH narrow output beats, least-significant slice first.
- Carries TKEEP/TLAST, drops trailing all-null slices of a packet's final beat, and runs at full output rate with back-to-back input acceptance.
- Sits between wide datapath stages (e.g. 512-bit) and narrower consumers (e.g. 256/128/64-bit) where data must be preserved, not trimmed.

---
 rtl/axis_downsizer.sv | 107 ++++++++++
 tb/tb_axis_downsizer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_downsizer.sv
// Splits each wide AXI-Stream beat into IN_WIDTH/OUT_WIDTH narrow beats, LSB slice first; first slice 1 cycle after accept.
// RX_TREADY is combinational from TX_TREADY only on the final slice, so back-to-back beats stream with no bubble.
module axis_downsizer #(
    parameter int IN_WIDTH  = 512,
    parameter int OUT_WIDTH = 256
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [IN_WIDTH-1:0]    AXIS_RX_TDATA,
    input  logic [IN_WIDTH/8-1:0]  AXIS_RX_TKEEP,
    input  logic                   AXIS_RX_TLAST,
    input  logic                   AXIS_RX_TVALID,
    output logic                   AXIS_RX_TREADY,
    output logic [OUT_WIDTH-1:0]   AXIS_TX_TDATA,
    output logic [OUT_WIDTH/8-1:0] AXIS_TX_TKEEP,
    output logic                   AXIS_TX_TLAST,
    output logic                   AXIS_TX_TVALID,
    input  logic                   AXIS_TX_TREADY
);
    localparam int R  = IN_WIDTH / OUT_WIDTH;
    localparam int KW = OUT_WIDTH / 8;
    localparam int IW = (R > 1) ? $clog2(R) : 1;
    localparam int RP = 1 << IW;

    generate
        if ((IN_WIDTH % OUT_WIDTH) != 0 || R < 2 || (OUT_WIDTH % 8) != 0) begin : g_bad_params
            $error("axis_downsizer: IN_WIDTH must be a multiple of OUT_WIDTH with ratio >= 2, OUT_WIDTH a multiple of 8");
        end
    endgenerate

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_BUSY  = 1'b1
    } state_t;

    state_t                 r_state;
    logic [IN_WIDTH-1:0]    r_data;
    logic [IN_WIDTH/8-1:0]  r_keep;
    logic                   r_last;
    logic [IW-1:0]          r_idx;
    logic [IW-1:0]          r_fin;

    logic [IW-1:0]          w_fin_kept;
    logic [IW-1:0]          w_fin;
    logic                   w_at_fin;
    logic                   w_rx_hs;
    logic                   w_tx_hs;
    logic [OUT_WIDTH-1:0]   w_dslice [RP];
    logic [KW-1:0]          w_kslice [RP];

    // Highest slice carrying any kept byte; an all-null final beat still emits slice 0.
    always_comb begin
        w_fin_kept = '0;
        for (int s = 0; s < R; s++) begin
            if (|AXIS_RX_TKEEP[s*KW +: KW]) begin
                w_fin_kept = IW'(s);
            end
        end
    end

    assign w_fin    = AXIS_RX_TLAST ? w_fin_kept : IW'(R - 1);
    assign w_at_fin = (r_idx == r_fin);

    assign AXIS_RX_TREADY = (r_state == S_EMPTY) | (AXIS_TX_TREADY & w_at_fin);
    assign w_rx_hs        = AXIS_RX_TVALID & AXIS_RX_TREADY;
    assign w_tx_hs        = AXIS_TX_TVALID & AXIS_TX_TREADY;

    // Padded to a power of two so a non-power-of-two ratio never indexes out of range.
    for (genvar g = 0; g < RP; g++) begin : g_slice
        if (g < R) begin : g_real
            assign w_dslice[g] = r_data[g*OUT_WIDTH +: OUT_WIDTH];
            assign w_kslice[g] = r_keep[g*KW +: KW];
        end else begin : g_pad
            assign w_dslice[g] = '0;
            assign w_kslice[g] = '0;
        end
    end

    assign AXIS_TX_TDATA  = w_dslice[r_idx];
    assign AXIS_TX_TKEEP  = w_kslice[r_idx];
    assign AXIS_TX_TLAST  = r_last & w_at_fin;
    assign AXIS_TX_TVALID = (r_state == S_BUSY);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_EMPTY;
            r_data  <= '0;
            r_keep  <= '0;
            r_last  <= 1'b0;
            r_idx   <= '0;
            r_fin   <= '0;
        end else if (w_rx_hs) begin
            r_state <= S_BUSY;
            r_data  <= AXIS_RX_TDATA;
            r_keep  <= AXIS_RX_TKEEP;
            r_last  <= AXIS_RX_TLAST;
            r_idx   <= '0;
            r_fin   <= w_fin;
        end else if (w_tx_hs) begin
            if (w_at_fin) begin
                r_state <= S_EMPTY;
            end else begin
                r_idx <= r_idx + IW'(1);
            end
        end
    end
endmodule

// File: tb/tb_axis_downsizer.sv
// Directed checks on a 512->256 instance and a randomized scoreboard run on a 512->64 instance.
module tb_axis_downsizer;
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    logic [511:0] a_rx_dat;
    logic [63:0]  a_rx_keep;
    logic         a_rx_last, a_rx_vld, a_rx_rdy;
    logic [255:0] a_tx_dat;
    logic [31:0]  a_tx_keep;
    logic         a_tx_last, a_tx_vld, a_tx_rdy;

    logic [511:0] b_rx_dat;
    logic [63:0]  b_rx_keep;
    logic         b_rx_last, b_rx_vld, b_rx_rdy;
    logic [63:0]  b_tx_dat;
    logic [7:0]   b_tx_keep;
    logic         b_tx_last, b_tx_vld, b_tx_rdy;
    logic         b_rand_rdy = 1'b0;

    int checks = 0;
    int errors = 0;

    axis_downsizer #(.IN_WIDTH(512), .OUT_WIDTH(256)) dut_a (
        .clk(clk), .resetn(resetn),
        .AXIS_RX_TDATA(a_rx_dat), .AXIS_RX_TKEEP(a_rx_keep), .AXIS_RX_TLAST(a_rx_last),
        .AXIS_RX_TVALID(a_rx_vld), .AXIS_RX_TREADY(a_rx_rdy),
        .AXIS_TX_TDATA(a_tx_dat), .AXIS_TX_TKEEP(a_tx_keep), .AXIS_TX_TLAST(a_tx_last),
        .AXIS_TX_TVALID(a_tx_vld), .AXIS_TX_TREADY(a_tx_rdy)
    );

    axis_downsizer #(.IN_WIDTH(512), .OUT_WIDTH(64)) dut_b (
        .clk(clk), .resetn(resetn),
        .AXIS_RX_TDATA(b_rx_dat), .AXIS_RX_TKEEP(b_rx_keep), .AXIS_RX_TLAST(b_rx_last),
        .AXIS_RX_TVALID(b_rx_vld), .AXIS_RX_TREADY(b_rx_rdy),
        .AXIS_TX_TDATA(b_tx_dat), .AXIS_TX_TKEEP(b_tx_keep), .AXIS_TX_TLAST(b_tx_last),
        .AXIS_TX_TVALID(b_tx_vld), .AXIS_TX_TREADY(b_tx_rdy)
    );

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Number of narrow beats a wide beat produces: all slices, or up to the last kept slice of a final beat.
    function automatic int n_slices(input logic [63:0] keep, input logic last, input int r, input int kw);
        int n;
        if (!last) return r;
        n = 1;
        for (int s = 0; s < r; s++) begin
            if (((keep >> (s*kw)) & ((64'd1 << kw) - 64'd1)) != 64'd0) n = s + 1;
        end
        return n;
    endfunction

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } nb_t;
    nb_t  b_q[$];
    nb_t  b_prev;
    logic b_prev_stall = 1'b0;
    int   b_beats_out = 0;

    always @(posedge clk) begin
        #1;
        if (b_rand_rdy) b_tx_rdy = 1'($urandom_range(0, 1));
    end

    always @(negedge clk) begin
        if (!resetn) begin
            b_prev_stall = 1'b0;
        end else begin
            if (b_rx_vld && b_rx_rdy) begin
                int n;
                n = n_slices(b_rx_keep, b_rx_last, 8, 8);
                for (int s = 0; s < n; s++)
                    b_q.push_back('{d: b_rx_dat[s*64 +: 64], k: b_rx_keep[s*8 +: 8], l: b_rx_last && (s == n-1)});
            end
            if (b_prev_stall) begin
                chk("b_stall_vld", b_tx_vld, 1'b1);
                chk("b_stall_dat", {b_tx_dat, b_tx_keep, b_tx_last}, b_prev);
            end
            if (b_tx_vld && b_tx_rdy) begin
                b_beats_out++;
                if (b_q.size() == 0) begin
                    chk("b_sb_level", b_q.size(), 1);
                end else begin
                    nb_t e;
                    e = b_q.pop_front();
                    chk("b_sb_beat", {b_tx_dat, b_tx_keep, b_tx_last}, e);
                end
            end
            b_prev_stall = b_tx_vld && !b_tx_rdy;
            b_prev       = '{d: b_tx_dat, k: b_tx_keep, l: b_tx_last};
        end
    end

    task automatic a_send(input logic [511:0] d, input logic [63:0] k, input logic l);
        @(posedge clk); #1;
        a_rx_dat = d; a_rx_keep = k; a_rx_last = l; a_rx_vld = 1'b1;
        @(negedge clk);
        chk("a_acc_rdy", a_rx_rdy, 1'b1);
        @(posedge clk); #1;
        a_rx_vld = 1'b0;
    endtask

    task automatic a_expect(input string tag, input logic [255:0] d, input logic [31:0] k, input logic l);
        @(negedge clk);
        chk({tag, "_vld"}, a_tx_vld, 1'b1);
        chk({tag, "_dat"}, a_tx_dat, d);
        chk({tag, "_keep"}, a_tx_keep, k);
        chk({tag, "_last"}, a_tx_last, l);
    endtask

    initial begin
        #600000;
        errors++;
        $display("FAIL watchdog expired observed=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        logic [511:0] d, d2;
        logic [511:0] cb [8];
        logic [63:0]  k, mask;
        int cur, waited, kslices;
        logic l;

        resetn = 1'b0;
        a_rx_dat = '0; a_rx_keep = '0; a_rx_last = 1'b0; a_rx_vld = 1'b0; a_tx_rdy = 1'b1;
        b_rx_dat = '0; b_rx_keep = '0; b_rx_last = 1'b0; b_rx_vld = 1'b0; b_tx_rdy = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_vld", a_tx_vld, 1'b0);
        chk("rst_last", a_tx_last, 1'b0);
        chk("rst_dat", a_tx_dat, 256'd0);
        chk("rst_keep", a_tx_keep, 32'd0);
        chk("rst_b_vld", b_tx_vld, 1'b0);
        #1 resetn = 1'b1;
        @(negedge clk);
        chk("rst_rdy", a_rx_rdy, 1'b1);

        // A/B pattern beat
        d = {{64{4'hB}}, {64{4'hA}}};
        a_send(d, '1, 1'b1);
        a_expect("ab0", d[255:0], '1, 1'b0);
        a_expect("ab1", d[511:256], '1, 1'b1);
        @(negedge clk);
        chk("ab_idle", a_tx_vld, 1'b0);

        // eight back-to-back beats
        for (int i = 0; i < 8; i++)
            for (int w = 0; w < 16; w++) cb[i][w*32 +: 32] = $urandom;
        @(posedge clk); #1;
        a_rx_dat = cb[0]; a_rx_keep = '1; a_rx_last = 1'b0; a_rx_vld = 1'b1;
        cur = 0;
        for (int i = 0; i <= 16; i++) begin
            @(negedge clk);
            chk("strm_rdy", a_rx_rdy, 1'((i % 2) == 0));
            if (i > 0) begin
                chk("strm_vld", a_tx_vld, 1'b1);
                chk("strm_dat", a_tx_dat, cb[(i-1)/2][((i-1)%2)*256 +: 256]);
                chk("strm_last", a_tx_last, 1'b0);
            end
            @(posedge clk); #1;
            if ((i % 2) == 0 && cur < 8) begin
                cur++;
                if (cur < 8) a_rx_dat = cb[cur];
                else a_rx_vld = 1'b0;
            end
        end
        @(negedge clk);
        chk("strm_idle", a_tx_vld, 1'b0);

        // final beat with only the lower slice kept
        d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
             $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        a_send(d, 64'h0000_0000_FFFF_FFFF, 1'b1);
        a_expect("half", d[255:0], 32'hFFFF_FFFF, 1'b1);
        @(negedge clk);
        chk("half_idle", a_tx_vld, 1'b0);

        // final beat with nothing kept
        a_send(d, 64'd0, 1'b1);
        a_expect("null", d[255:0], 32'd0, 1'b1);
        @(negedge clk);
        chk("null_idle", a_tx_vld, 1'b0);

        // sparse keep on a non-final beat passes through untouched
        a_send(d, 64'h00FF_0000_0000_00F0, 1'b0);
        a_expect("sparse0", d[255:0], 32'h0000_00F0, 1'b0);
        a_expect("sparse1", d[511:256], 32'h00FF_0000, 1'b0);

        // final beat whose only kept byte is in the upper slice
        a_send(d, 64'h0000_0001_0000_0000, 1'b1);
        a_expect("upper0", d[255:0], 32'd0, 1'b0);
        a_expect("upper1", d[511:256], 32'h0000_0001, 1'b1);

        // reset while the second slice is pending
        a_send(d, '1, 1'b0);
        @(negedge clk);
        @(posedge clk); #1;
        chk("mid_vld_pre", a_tx_vld, 1'b1);
        resetn = 1'b0;
        #1;
        chk("mid_vld_rst", a_tx_vld, 1'b0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk);
        chk("mid_rdy", a_rx_rdy, 1'b1);
        chk("mid_idle", a_tx_vld, 1'b0);
        d2 = ~d;
        a_send(d2, '1, 1'b1);
        a_expect("mid_s0", d2[255:0], '1, 1'b0);
        a_expect("mid_s1", d2[511:256], '1, 1'b1);

        // randomized 512->64 stream against the scoreboard
        b_rand_rdy = 1'b1;
        for (int bt = 0; bt < 1000; bt++) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 3) == 0) begin
                b_rx_vld = 1'b0;
                @(posedge clk); #1;
            end
            for (int w = 0; w < 16; w++) b_rx_dat[w*32 +: 32] = $urandom;
            l = ($urandom_range(0, 3) == 0);
            k = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 0) k = '1;
            if (l) begin
                kslices = $urandom_range(0, 8);
                mask = (kslices == 8) ? '1 : ((64'd1 << (kslices*8)) - 64'd1);
                k = k & mask;
            end
            b_rx_keep = k; b_rx_last = l; b_rx_vld = 1'b1;
            waited = 0;
            forever begin
                @(negedge clk);
                if (b_rx_rdy) break;
                waited++;
                if (waited > 200) break;
            end
            if (!b_rx_rdy) begin
                chk("b_rx_timeout", b_rx_rdy, 1'b1);
                break;
            end
        end
        @(posedge clk); #1;
        b_rx_vld = 1'b0;
        waited = 0;
        while (b_q.size() != 0 && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        chk("b_drain", b_q.size(), 0);
        chk("b_some_out", b_beats_out > 1000, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
